// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock time-setting path.
// Holds the setter FSM encoding and the per-digit BCD limits.
package alarm_clock_pkg;

   typedef enum logic [2:0] {
      IDLE,
      EDIT_HT,
      EDIT_HO,
      EDIT_MT,
      EDIT_MO,
      COMMIT
   } state_t;

   localparam logic [3:0] MAX_HT    = 4'd2;
   localparam logic [3:0] MAX_HO    = 4'd9;
   localparam logic [3:0] MAX_HO_20 = 4'd3;
   localparam logic [3:0] MAX_MT    = 4'd5;
   localparam logic [3:0] MAX_MO    = 4'd9;

   function automatic logic [3:0] bcd_inc(
      input logic [3:0] d,
      input logic [3:0] max
   );
      return (d >= max) ? 4'd0 : d + 4'd1;
   endfunction

   function automatic logic [1:0] pos_of(input state_t s);
      case (s)
         EDIT_HT: return 2'b11;
         EDIT_HO: return 2'b10;
         EDIT_MT: return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   function automatic state_t next_edit(input state_t s);
      case (s)
         EDIT_HT: return EDIT_HO;
         EDIT_HO: return EDIT_MT;
         EDIT_MT: return EDIT_MO;
         default: return EDIT_HT;
      endcase
   endfunction

endpackage

// File: rtl/time_setter_if.sv
// Bundle between the user controls, the live clock and the setter.
// master drives buttons and live time; slave returns edited digits.
interface time_setter_if;

   logic       mode_setcurrent;
   logic       btn_next;
   logic       btn_inc;
   logic [3:0] cur_first;
   logic [3:0] cur_second;
   logic [3:0] cur_third;
   logic [3:0] cur_fourth;
   logic [3:0] set_first;
   logic [3:0] set_second;
   logic [3:0] set_third;
   logic [3:0] set_fourth;
   logic [1:0] edit_pos;
   logic       set_load;

   modport master (
      output mode_setcurrent, btn_next, btn_inc,
      output cur_first, cur_second, cur_third, cur_fourth,
      input  set_first, set_second, set_third, set_fourth,
      input  edit_pos, set_load
   );

   modport slave (
      input  mode_setcurrent, btn_next, btn_inc,
      input  cur_first, cur_second, cur_third, cur_fourth,
      output set_first, set_second, set_third, set_fourth,
      output edit_pos, set_load
   );

endinterface

// File: rtl/edge_detect.sv
// Registered-history edge detector for already-debounced levels.
// rise/fall are valid in the cycle the level first differs.
module edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic q;

   // remember last sampled level; cleared so a high level after reset is an edge
   always_ff @(posedge clk) begin
      if (!rst_n) q <= 1'b0;
      else        q <= d;
   end

   assign rise = d & ~q;
   assign fall = ~d & q;

endmodule

// File: rtl/time_setter.sv
// HH:MM time editor: tracks live time, edits one BCD digit at a time,
// and pulses set_load once when the user leaves edit mode.
module time_setter
   import alarm_clock_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   time_setter_if.slave  bus
);

   state_t     state;
   logic [3:0] d1, d2, d3, d4;
   logic [1:0] pos;
   logic       load;
   logic       mode_rise, mode_fall;
   logic       next_rise, next_fall;
   logic       inc_rise, inc_fall;
   logic       unused_falls;
   logic [3:0] ht_inc;

   edge_detect u_mode (
      .clk(clk), .rst_n(rst_n), .d(bus.mode_setcurrent),
      .rise(mode_rise), .fall(mode_fall)
   );
   edge_detect u_next (
      .clk(clk), .rst_n(rst_n), .d(bus.btn_next),
      .rise(next_rise), .fall(next_fall)
   );
   edge_detect u_inc (
      .clk(clk), .rst_n(rst_n), .d(bus.btn_inc),
      .rise(inc_rise), .fall(inc_fall)
   );

   assign unused_falls = next_fall ^ inc_fall;
   assign ht_inc = bcd_inc(d4, MAX_HT);

   // setter FSM: tracking, per-digit editing, one-shot commit
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         d1    <= 4'd0;
         d2    <= 4'd0;
         d3    <= 4'd0;
         d4    <= 4'd0;
         pos   <= 2'b00;
         load  <= 1'b0;
      end else begin
         load <= 1'b0;
         unique case (state)
            IDLE: begin
               if (mode_rise) begin
                  state <= EDIT_HT;
                  pos   <= pos_of(EDIT_HT);
               end else begin
                  d1 <= bus.cur_first;
                  d2 <= bus.cur_second;
                  d3 <= bus.cur_third;
                  d4 <= bus.cur_fourth;
               end
            end
            COMMIT: begin
               state <= IDLE;
               pos   <= 2'b00;
            end
            default: begin
               if (mode_fall) begin
                  state <= COMMIT;
                  pos   <= 2'b00;
                  load  <= 1'b1;
               end else begin
                  if (inc_rise) begin
                     unique case (state)
                        EDIT_HT: begin
                           d4 <= ht_inc;
                           if (ht_inc == MAX_HT && d3 > MAX_HO_20)
                              d3 <= MAX_HO_20;
                        end
                        EDIT_HO: d3 <= bcd_inc(d3,
                           (d4 == MAX_HT) ? MAX_HO_20 : MAX_HO);
                        EDIT_MT: d2 <= bcd_inc(d2, MAX_MT);
                        EDIT_MO: d1 <= bcd_inc(d1, MAX_MO);
                        default: ;
                     endcase
                  end
                  if (next_rise) begin
                     state <= next_edit(state);
                     pos   <= pos_of(next_edit(state));
                  end
               end
            end
         endcase
      end
   end

   assign bus.set_first  = d1;
   assign bus.set_second = d2;
   assign bus.set_third  = d3;
   assign bus.set_fourth = d4;
   assign bus.edit_pos   = pos;
   assign bus.set_load   = load;

endmodule

// File: doc/time_setter.md
TIME_SETTER -- requirements
Module: time_setter

Interface
REQ-001 No parameters; the block is fixed for 24-hour HH:MM, 4 BCD digits.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 mode_setcurrent  in  1  level; 1 = user editing current time (same signal the display mux consumes).
REQ-005 btn_next  in  1  level, synchronized and debounced; rising edge advances edit position.
REQ-006 btn_inc  in  1  level, synchronized and debounced; rising edge increments selected digit.
REQ-007 cur_first, cur_second, cur_third, cur_fourth  in  4 each  live time BCD digits (minute ones, minute tens, hour ones, hour tens).
REQ-008 set_first, set_second, set_third, set_fourth  out  4 each  edited BCD digits, same digit order, to the display mux and the timekeeper.
REQ-009 edit_pos  out  2  selected digit in display refresh encoding: 11 = fourth, 10 = third, 01 = second, 00 = first.
REQ-010 set_load  out  1  one-cycle pulse: timekeeper loads set_* digits.

Function
REQ-011 The FSM SHALL have the states IDLE, EDIT_HT, EDIT_HO, EDIT_MT, EDIT_MO and COMMIT.
REQ-012 In IDLE, set_* SHALL track cur_* every cycle.
REQ-013 A rising edge of mode_setcurrent in IDLE SHALL hold set_* at the last tracked values and enter EDIT_HT on the next cycle.
REQ-014 A btn_next rising edge SHALL advance EDIT_HT->EDIT_HO->EDIT_MT->EDIT_MO->EDIT_HT, wrapping at the end.
REQ-015 A btn_inc rising edge SHALL increment the selected digit by 1 in the following cycle.
REQ-016 Increment ranges, wrapping to 0:
- set_fourth 0-2.
- set_third 0-9, or 0-3 when set_fourth = 2.
- set_second 0-5.
- set_first 0-9.
REQ-017 When set_fourth becomes 2 while set_third > 3, set_third SHALL be clamped to 3 in the same update.
REQ-018 If btn_inc and btn_next edges occur in the same cycle, the increment SHALL apply to the current digit, then the position SHALL advance.
REQ-019 Only rising edges act; a held button SHALL produce exactly one action.
REQ-020 A falling edge of mode_setcurrent in any EDIT state SHALL enter COMMIT; button edges in that cycle SHALL be ignored.
REQ-021 In COMMIT, set_load SHALL be 1 for exactly one cycle with set_* stable; the next state SHALL be IDLE.
REQ-022 set_* SHALL hold during COMMIT and resume tracking cur_* in IDLE on the following cycle.
REQ-023 edit_pos SHALL be 11/10/01/00 in EDIT_HT/HO/MT/MO, and 00 in IDLE and COMMIT.
REQ-024 All outputs SHALL be registered; a button-edge-to-digit-change latency of 1 cycle after edge detection.

Reset
REQ-025 With rst_n = 0 at a clock edge:
- state SHALL become IDLE.
- set_* SHALL become 0.
- edit_pos SHALL become 00.
- set_load SHALL become 0.
- the edge-detect history SHALL be cleared to 0.
REQ-026 Reset mid-edit SHALL discard edits without a set_load pulse.
REQ-027 After reset, mode_setcurrent already high SHALL count as a rising edge.

Structure
REQ-028 The state encoding and the per-digit maximum constants (2, 9, 3, 5) SHALL reside in shared package alarm_clock_pkg.
REQ-029 Rising-edge detection SHALL be one reusable sub-module, edge_detect, instantiated for btn_next, btn_inc and mode_setcurrent; the falling edge of mode_setcurrent SHALL be derived from the same instance.

Verification
REQ-030 Load and commit:
- cur = 1,2,3,4 (fourth..first); raise mode_setcurrent -> EDIT_HT with set = 1,2,3,4.
- drop mode_setcurrent -> single set_load with 1,2,3,4.
REQ-031 Wrap: in EDIT_MT with set_second = 5, one btn_inc -> set_second = 0; other digits unchanged.
REQ-032 Clamp:
- set = 1,9,0,0; btn_inc in EDIT_HT -> set = 2,3,0,0.
- further btn_inc in EDIT_HO -> set_third = 0.
REQ-033 Simultaneous edges: btn_inc and btn_next in EDIT_MO with set_first = 9 -> set_first = 0 and state EDIT_HT.
REQ-034 Held button: btn_inc held high 20 cycles -> exactly one increment.
REQ-035 Reset mid-edit: rst_n low during EDIT_HO -> set = 0,0,0,0, edit_pos = 00, no set_load.
